// File: rtl/alu2_bist_ctrl.sv
// rtl/alu2_bist_ctrl.sv - BIST controller: LFSR pattern source and MISR compactor for the alu4_cl ALU
//
// Purpose: drives pseudo-random 10-bit patterns onto the ALU inputs and
// compacts its 6-bit responses into a signature. It reports a pass/fail
// verdict against a supplied golden signature.
//
// Optional feature macro: ALU2_BIST_RESP_REG_EN
//   defined   - resp_in is registered before the MISR, and one DRAIN cycle
//               absorbs the final response.
//   undefined - resp_in feeds the MISR directly, and RUN goes straight to DONE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (honoured in IDLE or DONE only)
//   busy       out  high in RUN and DRAIN
//   done       out  high in DONE until the next accepted start
//   pat_out    out  [9:0] pattern to the ALU (bit i -> pi<i>)
//   resp_in    in   [5:0] ALU response (bit i <- po<i>)
//   golden     in   [5:0] expected signature
//   signature  out  [5:0] MISR contents
//   pat_count  out  [9:0] responses absorbed in the current/last run
//   pass       out  done & (signature == golden)

module alu2_bist_ctrl #(
  parameter int         PATTERNS = 1023,
  parameter logic [9:0] SEED     = 10'h001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [9:0] pat_out,
  input  logic [5:0] resp_in,
  input  logic [5:0] golden,
  output logic [5:0] signature,
  output logic [9:0] pat_count,
  output logic       pass
);

  // An all-zero seed would lock the LFSR up, so substitute 1.
  localparam logic [9:0] SEED_EFF = (SEED == 10'h000) ? 10'h001 : SEED;
  localparam logic [9:0] LAST_IDX = 10'(PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state;
  logic [9:0] lfsr;
  logic [9:0] drv_cnt;  // patterns already driven before the current cycle
  logic [5:0] sig;
  logic [9:0] cnt;
  logic       busy_q;
  logic       done_q;

`ifdef ALU2_BIST_RESP_REG_EN
  logic [5:0] resp_q;
  logic       resp_vld;  // resp_q holds a response not yet absorbed
`endif

  // MISR step for x^6+x+1: feedback from bit 5 enters bits 0 and 1.
  function automatic logic [5:0] misr_next(input logic [5:0] s, input logic [5:0] r);
    return {s[4] ^ r[5],
            s[3] ^ r[4],
            s[2] ^ r[3],
            s[1] ^ r[2],
            s[0] ^ s[5] ^ r[1],
            s[5] ^ r[0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= SEED_EFF;
      drv_cnt <= 10'd0;
      sig     <= 6'h00;
      cnt     <= 10'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU2_BIST_RESP_REG_EN
      resp_q   <= 6'h00;
      resp_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            lfsr    <= SEED_EFF;
            drv_cnt <= 10'd0;
            sig     <= 6'h00;
            cnt     <= 10'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef ALU2_BIST_RESP_REG_EN
            resp_vld <= 1'b0;
`endif
          end
        end

        RUN: begin
          lfsr    <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
          drv_cnt <= drv_cnt + 10'd1;
`ifdef ALU2_BIST_RESP_REG_EN
          // Absorb the previous cycle's response; the first RUN cycle has none.
          resp_q   <= resp_in;
          resp_vld <= 1'b1;
          if (resp_vld) begin
            sig <= misr_next(sig, resp_q);
            cnt <= cnt + 10'd1;
          end
          if (drv_cnt == LAST_IDX) begin
            state <= DRAIN;
          end
`else
          sig <= misr_next(sig, resp_in);
          cnt <= cnt + 10'd1;
          if (drv_cnt == LAST_IDX) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
`endif
        end

        DRAIN: begin
`ifdef ALU2_BIST_RESP_REG_EN
          sig      <= misr_next(sig, resp_q);
          cnt      <= cnt + 10'd1;
          resp_vld <= 1'b0;
`endif
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // The pattern is gated by the state so that it drops to zero outside RUN
  // without waiting for a clock, including during an asynchronous reset.
  assign pat_out   = (state == RUN) ? lfsr : 10'h000;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig;
  assign pat_count = cnt;
  assign pass      = done_q & (sig == golden);

endmodule

// File: tb/tb_alu2_bist_ctrl.sv
// tb/tb_alu2_bist_ctrl.sv - directed self-checking bench for alu2_bist_ctrl
module tb_alu2_bist_ctrl;

`ifdef ALU2_BIST_RESP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // PATTERNS=3 instance
  logic       start3 = 1'b0, busy3, done3, pass3;
  logic [9:0] pat3, cnt3;
  logic [5:0] resp3 = 6'h00, gold3 = 6'h00, sig3;
  // PATTERNS=2 instance
  logic       start2 = 1'b0, busy2, done2, pass2;
  logic [9:0] pat2, cnt2;
  logic [5:0] resp2 = 6'h3F, gold2 = 6'h02, sig2;
  // PATTERNS=1023 instance, driven by a combinational ALU stand-in
  logic       startf = 1'b0, busyf, donef, passf;
  logic [9:0] patf, cntf;
  logic [5:0] respf, goldf = 6'h00, sigf;

  function automatic logic [5:0] alu_f(input logic [9:0] p);
    return p[5:0] ^ {p[9:6], p[1:0]};
  endfunction

  function automatic logic [5:0] misr_step(input logic [5:0] s, input logic [5:0] r);
    logic [5:0] n;
    n[0] = s[5] ^ r[0];
    n[1] = s[0] ^ s[5] ^ r[1];
    for (int i = 2; i < 6; i++) n[i] = s[i-1] ^ r[i];
    return n;
  endfunction

  assign respf = alu_f(patf);

  alu2_bist_ctrl #(.PATTERNS(3), .SEED(10'h001)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .pat_out(pat3), .resp_in(resp3), .golden(gold3), .signature(sig3),
    .pat_count(cnt3), .pass(pass3));

  alu2_bist_ctrl #(.PATTERNS(2), .SEED(10'h001)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .pat_out(pat2), .resp_in(resp2), .golden(gold2), .signature(sig2),
    .pat_count(cnt2), .pass(pass2));

  alu2_bist_ctrl #(.PATTERNS(1023), .SEED(10'h001)) uf (
    .clk(clk), .rst_n(rst_n), .start(startf), .busy(busyf), .done(donef),
    .pat_out(patf), .resp_in(respf), .golden(goldf), .signature(sigf),
    .pat_count(cntf), .pass(passf));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] full_sig;

  task automatic compute_full_sig();
    logic [9:0] l;
    logic [5:0] s;
    l = 10'h001;
    s = 6'h00;
    repeat (1023) begin
      s = misr_step(s, alu_f(l));
      l = {l[8:0], l[9] ^ l[6]};
    end
    full_sig = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy3); end
    n_checks++; if (done3 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done3); end
    n_checks++; if (pat3 !== 10'h000) begin n_fail++; $display("FAIL reset_pat got %h want 000", pat3); end
    n_checks++; if (sig3 !== 6'h00) begin n_fail++; $display("FAIL reset_sig got %h want 00", sig3); end
    n_checks++; if (cnt3 !== 10'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt3); end
    n_checks++; if (pass3 !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass3); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [9:0] exp_pat [3];
    exp_pat[0] = 10'h001; exp_pat[1] = 10'h002; exp_pat[2] = 10'h004;
    resp3 = 6'h00;
    gold3 = 6'h00;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pat3 !== exp_pat[i]) begin n_fail++; $display("FAIL basic_pat%0d got %h want %h", i, pat3, exp_pat[i]); end
      n_checks++;
      if (busy3 !== 1'b1) begin n_fail++; $display("FAIL basic_busy%0d got %b want 1", i, busy3); end
      step();
    end
    n_checks++; if (pat3 !== 10'h000) begin n_fail++; $display("FAIL basic_pat_end got %h want 000", pat3); end
    repeat (LAT) step();
    n_checks++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done3); end
    n_checks++; if (sig3 !== 6'h00) begin n_fail++; $display("FAIL basic_sig got %h want 00", sig3); end
    n_checks++; if (cnt3 !== 10'd3) begin n_fail++; $display("FAIL basic_cnt got %0d want 3", cnt3); end
    n_checks++; if (pass3 !== 1'b1) begin n_fail++; $display("FAIL basic_pass got %b want 1", pass3); end
    step();
    n_checks++; if (done3 !== 1'b1 || cnt3 !== 10'd3) begin n_fail++; $display("FAIL basic_hold got done=%b cnt=%0d want 1/3", done3, cnt3); end
  endtask

  task automatic test_signature();
    resp2 = 6'h3F;
    gold2 = 6'h02;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (1 + LAT) step();
    n_checks++; if (sig2 !== 6'h3F) begin n_fail++; $display("FAIL sig_after1 got %h want 3f", sig2); end
    n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL sig_early_done got %b want 0", done2); end
    step();
    n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL sig_done got %b want 1", done2); end
    n_checks++; if (sig2 !== 6'h02) begin n_fail++; $display("FAIL sig_after2 got %h want 02", sig2); end
    n_checks++; if (pass2 !== 1'b1) begin n_fail++; $display("FAIL sig_pass_good got %b want 1", pass2); end
    gold2 = 6'h03;
    #1;
    n_checks++; if (pass2 !== 1'b0) begin n_fail++; $display("FAIL sig_pass_bad got %b want 0", pass2); end
  endtask

  task automatic test_full_run();
    logic seen [1024];
    int nseen, dups, c;
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    nseen = 0; dups = 0; c = 0;
    startf = 1'b1;
    step();
    startf = 1'b0;
    seen[patf] = 1'b1;
    nseen = 1;
    while (!donef && c < 1100) begin
      step();
      c++;
      if (patf != 10'h000) begin
        if (seen[patf]) dups++;
        else begin seen[patf] = 1'b1; nseen++; end
      end
    end
    n_checks++; if (c !== 1023 + LAT) begin n_fail++; $display("FAIL full_latency got %0d want %0d", c, 1023 + LAT); end
    n_checks++; if (nseen !== 1023) begin n_fail++; $display("FAIL full_distinct got %0d want 1023", nseen); end
    n_checks++; if (dups !== 0) begin n_fail++; $display("FAIL full_dups got %0d want 0", dups); end
    n_checks++; if (cntf !== 10'd1023) begin n_fail++; $display("FAIL full_cnt got %0d want 1023", cntf); end
    n_checks++; if (sigf !== full_sig) begin n_fail++; $display("FAIL full_sig got %h want %h", sigf, full_sig); end
  endtask

  task automatic test_async_reset();
    startf = 1'b1;
    step();
    startf = 1'b0;
    repeat (4) step();  // pattern 5 now on pat_out
    n_checks++; if (patf !== 10'h010) begin n_fail++; $display("FAIL rst_pat5 got %h want 010", patf); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busyf !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busyf); end
    n_checks++; if (patf !== 10'h000) begin n_fail++; $display("FAIL rst_pat got %h want 000", patf); end
    n_checks++; if (sigf !== 6'h00) begin n_fail++; $display("FAIL rst_sig got %h want 00", sigf); end
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (busyf !== 1'b0 || donef !== 1'b0) begin n_fail++; $display("FAIL rst_idle got busy=%b done=%b want 0/0", busyf, donef); end
    test_full_run();
  endtask

  task automatic test_start_held();
    int c;
    resp3 = 6'h3F;
    start3 = 1'b1;
    step();
    c = 0;
    n_checks++; if (pat3 !== 10'h001) begin n_fail++; $display("FAIL hold_p0 got %h want 001", pat3); end
    step();
    n_checks++; if (pat3 !== 10'h002) begin n_fail++; $display("FAIL hold_p1 got %h want 002", pat3); end
    step();
    n_checks++; if (pat3 !== 10'h004) begin n_fail++; $display("FAIL hold_p2 got %h want 004", pat3); end
    while (!done3 && c < 10) begin step(); c++; end
    n_checks++; if (c !== 1 + LAT) begin n_fail++; $display("FAIL hold_latency got %0d want %0d", c, 1 + LAT); end
    n_checks++; if (sig3 !== 6'h3B) begin n_fail++; $display("FAIL hold_sig got %h want 3b", sig3); end
    step();
    start3 = 1'b0;
    n_checks++; if (done3 !== 1'b0 || busy3 !== 1'b1) begin n_fail++; $display("FAIL hold_restart got done=%b busy=%b want 0/1", done3, busy3); end
    n_checks++; if (sig3 !== 6'h00 || cnt3 !== 10'd0) begin n_fail++; $display("FAIL hold_clear got sig=%h cnt=%0d want 00/0", sig3, cnt3); end
    n_checks++; if (pat3 !== 10'h001) begin n_fail++; $display("FAIL hold_restart_pat got %h want 001", pat3); end
  endtask

  initial begin
    compute_full_sig();
    test_reset();
    test_basic();
    test_signature();
    test_full_run();
    test_async_reset();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
